// File: rtl/koa_mult_arbiter.sv
// Two-port arbiter in front of one registered Karatsuba significand multiplier.
// Define KOA_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0 wins).
module koa_mult_arbiter #(
  parameter int SW     = 56,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_i,
  input  logic [SW-1:0]   a0_i,
  input  logic [SW-1:0]   b0_i,
  output logic            gnt0_o,
  input  logic            req1_i,
  input  logic [SW-1:0]   a1_i,
  input  logic [SW-1:0]   b1_i,
  output logic            gnt1_o,
  output logic [SW-1:0]   mul_a_o,
  output logic [SW-1:0]   mul_b_o,
  output logic            mul_load_o,
  input  logic [2*SW-1:0] mul_result_i,
  output logic [2*SW-1:0] result_o,
  output logic            done_o,
  output logic            done_id_o,
  output logic            busy_o
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, CALC, CAPT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          pick0;
  logic          pick1;

  // owner doubles as "last granted" for round-robin; it resets to 1 so port 0 wins first
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (state == IDLE && rst) begin
`ifdef KOA_ARB_RR_EN
      pick0 = req0_i & (~req1_i | owner);
      pick1 = req1_i & (~req0_i | ~owner);
`else
      pick0 = req0_i;
      pick1 = req1_i & ~req0_i;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    mul_load_o = 1'b0;
    case (state)
      IDLE: if (pick0 | pick1) state_nxt = CALC;
      CALC: begin
        if (cnt == '0) begin
          mul_load_o = 1'b1;
          state_nxt  = CAPT;
        end
      end
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (pick0 | pick1) begin
        owner <= pick1;
        cnt   <= CNT_INIT;
      end else if (state == CALC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // operands stay frozen from the grant edge so the KOA core settles as a multicycle path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a_o   <= '0;
      mul_b_o   <= '0;
      result_o  <= '0;
      done_o    <= 1'b0;
      done_id_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (pick0 | pick1) begin
        mul_a_o <= pick1 ? a1_i : a0_i;
        mul_b_o <= pick1 ? b1_i : b0_i;
      end
      if (state == CAPT) begin
        result_o  <= mul_result_i;
        done_o    <= 1'b1;
        done_id_o <= owner;
      end
    end
  end

  assign gnt0_o = pick0;
  assign gnt1_o = pick1;
  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_koa_mult_arbiter.sv
// Bench for koa_mult_arbiter: timeline-based reference model plus directed and random stimulus.
// Follows KOA_ARB_RR_EN the same way as the design to pick the expected arbitration policy.
module tb_koa_mult_arbiter;
  localparam int SW = 56;
  localparam int SETTLE = 2;
  localparam int PW = 2 * SW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [SW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          gnt0, gnt1, mul_load, done, done_id, busy;
  logic [SW-1:0] mul_a, mul_b;
  logic [PW-1:0] mul_result = '0;
  logic [PW-1:0] result;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in for the external multiplier: combinational product into a load-enabled register
  always @(posedge clk) if (mul_load) mul_result <= mul_a * mul_b;

  koa_mult_arbiter #(.SW(SW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .a0_i(a0), .b0_i(b0), .gnt0_o(gnt0),
    .req1_i(req1), .a1_i(a1), .b1_i(b1), .gnt1_o(gnt1),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_load_o(mul_load),
    .mul_result_i(mul_result), .result_o(result),
    .done_o(done), .done_id_o(done_id), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Reference model: an operation granted in cycle g is busy g+1..g+SETTLE+1,
  // loads at g+SETTLE and reports at g+SETTLE+2.
  int            g = -1;
  logic [SW-1:0] ma = '0, mb = '0;
  logic [PW-1:0] pend = '0, mres = '0;
  logic          pid = 1'b0, mid = 1'b0, mlast = 1'b1;

  always @(negedge clk) begin
    int  c;
    bit  idle, e0, e1;
    c = cyc;
    if (!rst) begin
      g = -1; ma = '0; mb = '0; mres = '0; mid = 1'b0; mlast = 1'b1;
      chk("rst_gnt0", gnt0, 0);   chk("rst_gnt1", gnt1, 0);
      chk("rst_busy", busy, 0);   chk("rst_load", mul_load, 0);
      chk("rst_done", done, 0);   chk("rst_id", done_id, 0);
      chk("rst_res", result, 0);  chk("rst_a", mul_a, 0); chk("rst_b", mul_b, 0);
    end else begin
      idle = (g < 0) || (c > g + SETTLE + 1);
      if (g >= 0 && c == g + SETTLE + 2) begin
        mres = pend;
        mid  = pid;
      end
      e0 = 1'b0; e1 = 1'b0;
      if (idle) begin
        if (req0 && req1) begin
`ifdef KOA_ARB_RR_EN
          e0 = mlast; e1 = !mlast;
`else
          e0 = 1'b1;
`endif
        end else begin
          e0 = req0; e1 = req1;
        end
      end
      chk("gnt0", gnt0, e0);
      chk("gnt1", gnt1, e1);
      chk("busy", busy, !idle);
      chk("mul_load", mul_load, (g >= 0 && c == g + SETTLE));
      chk("done", done, (g >= 0 && c == g + SETTLE + 2));
      chk("done_id", done_id, mid);
      chk("result", result, mres);
      chk("mul_a", mul_a, ma);
      chk("mul_b", mul_b, mb);
      if (e0 || e1) begin
        g     = c;
        ma    = e1 ? a1 : a0;
        mb    = e1 ? b1 : b0;
        pend  = PW'(ma) * PW'(mb);
        pid   = e1;
        mlast = e1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ends on the negedge where the grant is seen (ok=1), else after the budget
  task automatic await_gnt(input int port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((port == 0 && gnt0) || (port == 1 && gnt1) || (port == 2 && (gnt0 || gnt1))) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic await_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [SW-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(7))
      0: return '0;
      1: return '1;
      default: return r[SW-1:0];
    endcase
  endfunction

  initial begin
    bit ok;
    int t, prev, who;
    int order[3];
`ifdef KOA_ARB_RR_EN
    order = '{0, 1, 0};
`else
    order = '{0, 0, 0};
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // single operation 3*5, then req1 waiting across done
    a0 = 56'd3; b0 = 56'd5; req0 = 1'b1;
    @(negedge clk); chk("single_gnt0", gnt0, 1); t = cyc;
    tick(); req0 = 1'b0; a1 = 56'd2; b1 = 56'd4; req1 = 1'b1;
    @(negedge clk); chk("single_busy1", busy, 1);
    tick(); @(negedge clk); chk("single_load", mul_load, 1); chk("single_busy2", busy, 1);
    tick(); @(negedge clk); chk("single_busy3", busy, 1); chk("single_nodone", done, 0);
    tick(); @(negedge clk);
    chk("single_lat", cyc - t, SETTLE + 2);
    chk("single_done", done, 1); chk("single_res", result, 15); chk("single_id", done_id, 0);
    chk("b2b_gnt1", gnt1, 1);
    tick(); req1 = 1'b0;
    repeat (2) tick();
    @(negedge clk); chk("b2b_hold", result, 15);
    tick(); @(negedge clk);
    chk("b2b_done", done, 1); chk("b2b_res", result, 8); chk("b2b_id", done_id, 1);

    // extreme operands
    tick(); a0 = '1; b0 = '1; req0 = 1'b1;
    await_gnt(0, ok); chk("ext_gnt", ok, 1);
    tick(); req0 = 1'b0;
    await_done(ok); chk("ext_done", ok, 1);
    chk("ext_res", result, 112'hFFFFFFFFFFFFFE00000000000001);
    tick(); a0 = '0; b0 = rnd() | 56'd1; req0 = 1'b1;
    await_gnt(0, ok); chk("zero_gnt", ok, 1);
    tick(); req0 = 1'b0;
    await_done(ok); chk("zero_done", ok, 1); chk("zero_res", result, 0);

    // tie, both held for three operations
    tick(); a0 = 56'd11; b0 = 56'd13; a1 = 56'd17; b1 = 56'd19; req0 = 1'b1; req1 = 1'b1;
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      await_gnt(2, ok); chk("tie_gnt", ok, 1);
      chk("tie_dual", gnt0 && gnt1, 0);
      who = gnt1 ? 1 : 0;
      chk("tie_order", who, order[k]);
      if (prev >= 0) chk("tie_space", cyc - prev, SETTLE + 2);
      prev = cyc;
      tick();
    end
    req0 = 1'b0;
    await_gnt(1, ok); chk("tie_gnt1_after", ok, 1);
    chk("tie_space_last", cyc - prev, SETTLE + 2);
    tick(); req1 = 1'b0;
    await_done(ok); chk("tie_done", ok, 1); chk("tie_res", result, 323); chk("tie_id", done_id, 1);

    // reset in the middle of an operation
    tick(); a0 = 56'd7; b0 = 56'd9; req0 = 1'b1;
    await_gnt(0, ok); chk("rstmid_gnt", ok, 1);
    tick(); rst = 1'b0;
    @(negedge clk); chk("rstmid_busy", busy, 0); chk("rstmid_a", mul_a, 0);
    tick(); tick(); rst = 1'b1;
    await_gnt(0, ok); chk("rstmid_regnt", ok, 1);
    tick(); req0 = 1'b0;
    await_done(ok); chk("rstmid_done", ok, 1); chk("rstmid_res", result, 63);
    chk("rstmid_id", done_id, 0);

    // random traffic, including withdrawals
    for (int i = 0; i < 600; i++) begin
      bit s0, s1;
      @(negedge clk);
      s0 = gnt0; s1 = gnt1;
      tick();
      if (req0 && s0) req0 = 1'b0;
      else if (req0 && $urandom_range(15) == 0) req0 = 1'b0;
      else if (!req0 && $urandom_range(2) == 0) begin req0 = 1'b1; a0 = rnd(); b0 = rnd(); end
      if (req1 && s1) req1 = 1'b0;
      else if (req1 && $urandom_range(15) == 0) req1 = 1'b0;
      else if (!req1 && $urandom_range(2) == 0) begin req1 = 1'b1; a1 = rnd(); b1 = rnd(); end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/koa_mult_arbiter.md
# koa_mult_arbiter

- Shares one registered Karatsuba significand multiplier (combinational KOA core followed by a load-enabled result register) between two requesters, e.g. the FP multiply path and the FP divide/sqrt iteration path.
- Arbitrates requests and latches the winner's operands onto the multiplier inputs.
- Waits a parameterised settle time so the combinational KOA is treated as a multicycle path, pulses the multiplier's result-register load, then returns the product tagged with the owner id.

## Interface

Parameters:
- SW, 56, significand operand width; product width is 2*SW.
- SETTLE, 2, cycles operands are held stable before the multiplier load pulse; legal range is SETTLE ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0_i  in  1  requester 0 request; held until granted.
- a0_i, b0_i  in  SW  requester 0 operands, sampled in the grant cycle.
- gnt0_o  out  1  requester 0 grant, one-cycle pulse.
- req1_i, a1_i, b1_i, gnt1_o  same as requester 0, for requester 1.
- mul_a_o, mul_b_o  out  SW  operands to the multiplier Data_A_i/Data_B_i; registered.
- mul_load_o  out  1  to the multiplier load_b_i.
- mul_result_i  in  2*SW  from the multiplier sgf_result_o.
- result_o  out  2*SW  registered product.
- done_o  out  1  one-cycle pulse; result_o is valid.
- done_id_o  out  1  owner of the current result (0/1).
- busy_o  out  1  high in CALC and CAPT.

## Operation

FSM states: IDLE, CALC, CAPT.

- **IDLE**
  - If any req is high, the winner's gnt is asserted combinationally in this cycle.
  - At the edge: the winner's a/b load into mul_a_o/mul_b_o, owner is registered, cnt = SETTLE-1, go to CALC.
  - No request: stay in IDLE; all gnt low.
- **CALC**
  - mul_a_o/mul_b_o are held.
  - cnt decrements each cycle.
  - mul_load_o = 1 in the cycle cnt == 0, then go to CAPT.
- **CAPT**
  - result_o <= mul_result_i at the edge.
  - done_o and done_id_o are registered; they go high in the following cycle, which is IDLE.
  - Go to IDLE.

Rules:
- gnt is only asserted in IDLE. At most one gnt is high per cycle.
- A requester may drop req before it is granted; the request is treated as withdrawn.
- A request arriving during CALC/CAPT waits; no queueing beyond the held req.
- mul_a_o/mul_b_o and result_o hold their values until the next grant or capture, respectively.
- A new grant may occur in the same cycle as done_o.
- Arbitration is per Configuration.
- Widths: product is exactly 2*SW bits, unsigned; no rounding or normalisation here.
- Asynchronous reset (rst = 0), at any point including mid-operation:
  - State goes to IDLE, all outputs 0, owner = 1 so port 0 wins first.
  - The in-flight operation is dropped and no done_o is produced.

## Timing

Take the grant cycle as T.

- mul_a_o/mul_b_o valid from T+1.
- mul_load_o high at T+SETTLE.
- CAPT at T+SETTLE+1.
- done_o/result_o at T+SETTLE+2.
- Latency is SETTLE+2 cycles; throughput is one operation per SETTLE+2 cycles.

## Configuration

Macro: KOA_ARB_RR_EN.

- **Defined:** round-robin. On simultaneous requests, the port not granted last wins. A single requester is always granted.
- **Undefined:** fixed priority; port 0 always wins a tie. The owner register is still kept for done_id_o.

## Test plan

- Single operation, SETTLE=2, SW=56:
  - Stimulus: req0, a=3, b=5 (T=0).
  - Response: gnt0 at 0; mul_load at 2; done at 4 with result_o=15 and done_id=0; busy high cycles 1-3.
- Extreme operands:
  - Stimulus: a=b=2^56-1.
  - Response: result_o=2^112-2^57+1. Zero operand gives result 0.
- Tie with KOA_ARB_RR_EN, both req held for 3 operations:
  - Response: grant order 0,1,0.
  - Grants are spaced 4 cycles apart.
  - Each done_id matches its grant.
  - No dual grant.
- Tie without the macro, both req held:
  - Response: gnt0 every 4 cycles; gnt1 never asserted.
  - After req0 drops, gnt1 is asserted in the next IDLE.
- Reset mid-operation:
  - Stimulus: rst low at T+1 after a grant (a=7, b=9).
  - Response: all outputs 0; no done_o.
  - After release, a pending req0 is granted and produces 63.
- Back-to-back:
  - Stimulus: req1 held while done_o for req0 fires.
  - Response: gnt1 in the same cycle as done_o; result_o stays 15 until the next CAPT.
